// File: rtl/bomb_countdown_if.sv
// Button/display bundle for the bomb countdown controller.
// The master side (board or bench) drives the push-button triggers and
// watches the 7-segment and status outputs; the slave side is the controller.
interface bomb_countdown_if #(
   parameter int DIGITS = 4
);
   logic [3:0]          trigger;
   logic [8*DIGITS-1:0] hex;
   logic                exploded;
   logic                defused;

   modport master (
      output trigger,
      input  hex,
      input  exploded,
      input  defused
   );

   modport slave (
      input  trigger,
      output hex,
      output exploded,
      output defused
   );
endinterface

// File: rtl/bomb_countdown.sv
// Bomb-timer controller: BCD countdown with a built-in tick prescaler,
// arm/pause/defuse/preset control from four push buttons, and direct
// active-low 7-segment drive for every digit.
module bomb_countdown #(
   parameter int                  TICK_DIV = 50_000_000,
   parameter int                  DIGITS   = 4,
   parameter logic [4*DIGITS-1:0] PRESET   = 16'h0060
) (
   input  logic              clk,
   input  logic              rst,
   bomb_countdown_if.slave   bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = 4 * DIGITS;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ARMED    = 3'd1;
   localparam logic [2:0] ST_PAUSED   = 3'd2;
   localparam logic [2:0] ST_DEFUSED  = 3'd3;
   localparam logic [2:0] ST_EXPLODED = 3'd4;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [3:0]    trigMeta_q;
   logic [3:0]    trigSync_q;
   logic [3:0]    trigPrev_q;
   logic [3:0]    trigEdge_q;

   logic [2:0]    state_q,  state_d;
   logic [CW-1:0] count_q,  count_d;
   logic [PW-1:0] presc_q,  presc_d;
   logic          blink_q,  blink_d;

   logic          tick;
   logic [PW-1:0] prescNext;
   logic [CW-1:0] countInc;
   logic [CW-1:0] countDec;
   logic [8*DIGITS-1:0] hexOut;

   // BCD add-one across all digits; all-9s wraps to all-0s.
   function automatic logic [CW-1:0] bcdInc(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (v[4*k +: 4] >= 4'd9) begin
               r[4*k +: 4] = 4'd0;
            end else begin
               r[4*k +: 4] = v[4*k +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // BCD subtract-one with borrow; only ever applied to a non-zero count.
   function automatic logic [CW-1:0] bcdDec(input logic [CW-1:0] v);
      logic [CW-1:0] r;
      logic          borrow;
      r      = v;
      borrow = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (borrow) begin
            if (v[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = 4'd9;
            end else begin
               r[4*k +: 4] = v[4*k +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Active-low segments g..a for one BCD nibble; non-decimal nibbles go dark.
   function automatic logic [6:0] segDecode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Button conditioning: two-flop synchroniser, then a registered rising-edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trigMeta_q <= '0;
         trigSync_q <= '0;
         trigPrev_q <= '0;
         trigEdge_q <= '0;
      end else begin
         trigMeta_q <= bus.trigger;
         trigSync_q <= trigMeta_q;
         trigPrev_q <= trigSync_q;
         trigEdge_q <= trigSync_q & ~trigPrev_q;
      end
   end

   assign tick      = (presc_q == PRESC_LAST);
   assign prescNext = tick ? '0 : presc_q + 1'b1;
   assign countInc  = bcdInc(count_q);
   assign countDec  = bcdDec(count_q);

   // Next-state logic; within a cycle defuse beats pause, and pause beats the tick.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      blink_d = blink_q;
      case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            if (trigEdge_q[0]) begin
               if (count_q != '0) begin
                  state_d = ST_ARMED;
               end
            end else if (trigEdge_q[2]) begin
               count_d = countInc;
            end
         end
         ST_ARMED: begin
            presc_d = prescNext;
            if (trigEdge_q[3]) begin
               state_d = ST_DEFUSED;
            end else if (trigEdge_q[1]) begin
               state_d = ST_PAUSED;
            end else if (tick) begin
               count_d = countDec;
               if (countDec == '0) begin
                  state_d = ST_EXPLODED;
               end
            end
         end
         ST_PAUSED: begin
            if (trigEdge_q[3]) begin
               state_d = ST_DEFUSED;
            end else if (trigEdge_q[1]) begin
               state_d = ST_ARMED;
            end
         end
         ST_DEFUSED: begin
            if (trigEdge_q[0]) begin
               state_d = ST_IDLE;
               count_d = PRESET;
               presc_d = '0;
               blink_d = 1'b0;
            end
         end
         ST_EXPLODED: begin
            presc_d = prescNext;
            if (tick) begin
               blink_d = ~blink_q;
            end
            if (trigEdge_q[0]) begin
               state_d = ST_IDLE;
               count_d = PRESET;
               presc_d = '0;
               blink_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = PRESET;
            presc_d = '0;
            blink_d = 1'b0;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= PRESET;
         presc_q <= '0;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
         blink_q <= blink_d;
      end
   end

   // Display decode: dp lights when defused, every digit blanks during the explode blink.
   always_comb begin
      hexOut = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if ((state_q == ST_EXPLODED) && blink_q) begin
            hexOut[8*k +: 8] = 8'hFF;
         end else begin
            hexOut[8*k +: 8] = {(state_q != ST_DEFUSED), segDecode(count_q[4*k +: 4])};
         end
      end
   end

   assign bus.hex      = hexOut;
   assign bus.exploded = (state_q == ST_EXPLODED);
   assign bus.defused  = (state_q == ST_DEFUSED);

endmodule

// File: tb/tb_bomb_countdown.sv
// Directed bench for bomb_countdown with a fast tick (TICK_DIV=4),
// two digits and a preset of 03.
module tb_bomb_countdown;

   logic clk;
   logic rst;
   int   checkCount;
   int   passCount;

   bomb_countdown_if #(.DIGITS(2)) bus ();

   bomb_countdown #(
      .TICK_DIV (4),
      .DIGITS   (2),
      .PRESET   (8'h03)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 100 MHz clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Advance n rising edges and settle 1 ns after the last one.
   task automatic stepCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle button press; returns just after the edge where the controller reacts.
   task automatic applyStimulus(input logic [3:0] mask);
      bus.trigger = mask;
      stepCycles(1);
      bus.trigger = 4'b0000;
      stepCycles(3);
   endtask

   task automatic checkHex(input string tag, input logic [15:0] expected);
      checkOutput(tag, {16'h0, bus.hex}, {16'h0, expected});
   endtask

   initial begin
      logic [15:0] downHex [4];
      checkCount = 0;
      passCount  = 0;
      downHex[0] = 16'hC099;
      downHex[1] = 16'hC0B0;
      downHex[2] = 16'hC0A4;
      downHex[3] = 16'hC0F9;

      rst         = 1'b1;
      bus.trigger = 4'b0000;
      stepCycles(3);
      rst = 1'b0;
      stepCycles(1);
      $display("[TB] reset / preset");
      checkHex("reset_hex", 16'hC0B0);
      checkOutput("reset_exploded", 32'(bus.exploded), 32'd0);
      checkOutput("reset_defused", 32'(bus.defused), 32'd0);

      applyStimulus(4'b0100);
      checkHex("inc_04", 16'hC099);
      applyStimulus(4'b0100);
      checkHex("inc_05", 16'hC092);
      applyStimulus(4'b0100);
      checkHex("inc_06", 16'hC082);

      applyStimulus(4'b0001);
      stepCycles(3);
      checkHex("armed_hold_06", 16'hC082);
      stepCycles(1);
      checkHex("dec_05", 16'hC092);
      for (int i = 0; i < 4; i++) begin
         stepCycles(4);
         checkHex("dec_step", downHex[i]);
      end
      stepCycles(4);
      checkHex("dec_00", 16'hC0C0);
      checkOutput("explode_flag", 32'(bus.exploded), 32'd1);
      checkOutput("explode_defused", 32'(bus.defused), 32'd0);
      stepCycles(3);
      checkHex("blink_off", 16'hC0C0);
      stepCycles(1);
      checkHex("blink_on", 16'hFFFF);
      stepCycles(4);
      checkHex("blink_off2", 16'hC0C0);

      applyStimulus(4'b0001);
      checkHex("rearm_hex", 16'hC0B0);
      checkOutput("rearm_exploded", 32'(bus.exploded), 32'd0);

      $display("[TB] pause / resume");
      bus.trigger = 4'b0001;
      stepCycles(1);
      bus.trigger = 4'b0000;
      stepCycles(1);
      bus.trigger = 4'b0010;
      stepCycles(1);
      bus.trigger = 4'b0000;
      stepCycles(3);
      checkHex("pause_entry", 16'hC0B0);
      stepCycles(10);
      checkHex("pause_hold10", 16'hC0B0);
      stepCycles(10);
      checkHex("pause_hold20", 16'hC0B0);
      applyStimulus(4'b0010);
      checkHex("resume_edge", 16'hC0B0);
      stepCycles(1);
      checkHex("resume_plus1", 16'hC0B0);
      stepCycles(1);
      checkHex("resume_plus2", 16'hC0A4);

      $display("[TB] defuse priority");
      stepCycles(4);
      checkHex("pre_defuse_01", 16'hC0F9);
      applyStimulus(4'b1000);
      checkOutput("defuse_flag", 32'(bus.defused), 32'd1);
      checkOutput("defuse_exploded", 32'(bus.exploded), 32'd0);
      checkHex("defuse_hex", 16'h4079);
      stepCycles(5);
      checkHex("defuse_frozen", 16'h4079);
      applyStimulus(4'b0001);
      checkHex("defuse_rearm_hex", 16'hC0B0);
      checkOutput("defuse_rearm_flag", 32'(bus.defused), 32'd0);

      $display("[TB] wrap / boundary");
      for (int i = 0; i < 96; i++) begin
         applyStimulus(4'b0100);
      end
      checkHex("preset_99", 16'h9090);
      applyStimulus(4'b0100);
      checkHex("wrap_00", 16'hC0C0);
      applyStimulus(4'b0001);
      stepCycles(8);
      checkHex("arm_at_00_ignored", 16'hC0C0);
      checkOutput("arm_at_00_exploded", 32'(bus.exploded), 32'd0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(4'b0100);
      end
      checkHex("preset_10", 16'hF9C0);
      applyStimulus(4'b0001);
      stepCycles(4);
      checkHex("borrow_09", 16'hC090);

      $display("[TB] async reset mid-countdown");
      stepCycles(2);
      #3;
      rst = 1'b1;
      #1;
      checkHex("async_reset_hex", 16'hC0B0);
      checkOutput("async_reset_exploded", 32'(bus.exploded), 32'd0);
      checkOutput("async_reset_defused", 32'(bus.defused), 32'd0);
      stepCycles(1);
      rst = 1'b0;
      stepCycles(1);

      bus.trigger = 4'b0001;
      stepCycles(40);
      checkOutput("held_arm_single", 32'(bus.exploded), 32'd1);
      bus.trigger = 4'b0000;
      stepCycles(2);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
